// File: rtl/leb128_reader_pkg.sv
// Shared loader package: FSM state type and LEB128 field constants.
package wasm_pkg;

    localparam int unsigned LEB_MAX_BYTES    = 5;
    localparam int unsigned LEB_CONT_BIT     = 7;
    localparam logic [7:0]  LEB_PAYLOAD_MASK = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RESP
    } leb_state_t;

    // 7-bit payload placed at its group position; bits past 31 fall off.
    function automatic logic [31:0] leb_payload(input logic [7:0] b, input logic [2:0] count);
        logic [31:0] p;
        p = 32'(b & LEB_PAYLOAD_MASK);
        return p << (7 * int'(count));
    endfunction

endpackage

// File: rtl/leb128_reader_if.sv
// Loader-side request/response handshake of the LEB128 reader.
interface leb128_reader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_signed;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_value;
    logic [2:0]        rsp_len;
    logic [ADDR_W-1:0] rsp_next_addr;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_value, rsp_len, rsp_next_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_value, rsp_len, rsp_next_addr, rsp_err
    );
endinterface

// File: rtl/leb128_reader_rom_byte_cache.sv
// Single-entry address/byte cache so a repeated ROM address is served locally.
module rom_byte_cache #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [7:0]        fill_byte,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [7:0]        cache_byte
);
    logic              cache_vld;
    logic [ADDR_W-1:0] cache_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld  <= 1'b0;
            cache_addr <= '0;
            cache_byte <= '0;
        end else if (fill) begin
            cache_vld  <= 1'b1;
            cache_addr <= fill_addr;
            cache_byte <= fill_byte;
        end
    end

    assign hit = cache_vld && (cache_addr == lookup_addr);
endmodule

// File: rtl/leb128_reader.sv
// LEB128 varint reader over the ROM byte interface (u32; s32 when LEB128_SIGNED_EN is defined).
module leb128_reader
    import wasm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BYTES = LEB_MAX_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    leb128_reader_if.slave    bus,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read_en,
    input  logic [7:0]        rom_data,
    input  logic              rom_ready
);
    localparam logic [2:0] MAX_CNT = 3'(MAX_BYTES);

    leb_state_t        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        count;
    logic [31:0]       acc;
`ifdef LEB128_SIGNED_EN
    logic              sgn;
`endif

    logic [ADDR_W-1:0] lookup_addr;
    logic              hit;
    logic [7:0]        cache_byte;
    logic              cache_fill;
    logic              byte_vld;
    logic [7:0]        cur_byte;
    logic [31:0]       acc_nxt;
    logic [31:0]       value_nxt;
    logic [2:0]        cnt_nxt;
    logic              last_byte;
    logic              overrun;
    logic              final_bad;
    logic              err_nxt;

    rom_byte_cache #(.ADDR_W(ADDR_W)) u_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill       (cache_fill),
        .fill_addr  (cur_addr),
        .fill_byte  (rom_data),
        .lookup_addr(lookup_addr),
        .hit        (hit),
        .cache_byte (cache_byte)
    );

    // In IDLE the cache is probed with the incoming address so a hit skips the ROM strobe.
    always_comb begin
        lookup_addr = (state == ST_IDLE) ? bus.req_addr : cur_addr;
        byte_vld    = (state == ST_FETCH) && (hit || rom_ready);
        cache_fill  = (state == ST_FETCH) && !hit && rom_ready;
        cur_byte    = hit ? cache_byte : rom_data;
        acc_nxt     = acc | leb_payload(cur_byte, count);
        cnt_nxt     = count + 3'd1;
        last_byte   = !cur_byte[LEB_CONT_BIT];
        overrun     = cur_byte[LEB_CONT_BIT] && (cnt_nxt == MAX_CNT);
        final_bad   = (cur_byte[6:4] != 3'b000);
        value_nxt   = acc_nxt;
`ifdef LEB128_SIGNED_EN
        if (sgn) begin
            final_bad = (cur_byte[6:3] != 4'h0) && (cur_byte[6:3] != 4'hF);
            if (7 * int'(cnt_nxt) < 32)
                value_nxt = 32'($signed(acc_nxt << (32 - 7 * int'(cnt_nxt))) >>> (32 - 7 * int'(cnt_nxt)));
        end
`endif
        err_nxt     = overrun || ((cnt_nxt == MAX_CNT) && final_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cur_addr          <= '0;
            base_addr         <= '0;
            count             <= '0;
            acc               <= '0;
`ifdef LEB128_SIGNED_EN
            sgn               <= 1'b0;
`endif
            bus.req_ready     <= 1'b1;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_err       <= 1'b0;
            bus.rsp_value     <= '0;
            bus.rsp_len       <= '0;
            bus.rsp_next_addr <= '0;
            rom_read_en       <= 1'b0;
            rom_addr          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        state         <= ST_FETCH;
                        cur_addr      <= bus.req_addr;
                        base_addr     <= bus.req_addr;
                        count         <= '0;
                        acc           <= '0;
`ifdef LEB128_SIGNED_EN
                        sgn           <= bus.req_signed;
`endif
                        bus.req_ready <= 1'b0;
                        rom_addr      <= bus.req_addr;
                        rom_read_en   <= !hit;
                    end
                end
                ST_FETCH: begin
                    if (byte_vld) begin
                        if (last_byte || overrun) begin
                            state             <= ST_RESP;
                            rom_read_en       <= 1'b0;
                            bus.rsp_valid     <= 1'b1;
                            bus.rsp_value     <= value_nxt;
                            bus.rsp_len       <= cnt_nxt;
                            bus.rsp_next_addr <= base_addr + ADDR_W'(cnt_nxt);
                            bus.rsp_err       <= err_nxt;
                        end else begin
                            count       <= cnt_nxt;
                            acc         <= acc_nxt;
                            cur_addr    <= cur_addr + ADDR_W'(1);
                            rom_addr    <= cur_addr + ADDR_W'(1);
                            rom_read_en <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_leb128_reader.sv
// Scoreboard bench for leb128_reader: directed requests against a ROM model that never repeats an address.
module tb_leb128_reader;
    typedef struct {
        logic [31:0] value;
        logic [2:0]  len;
        logic [31:0] nxt;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic        rom_read_en;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_ready = 1'b0;
    logic [31:0] rom_last = '1;
    int          rom_reads = 0;
    int          en_cycles = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [256];
    exp_t        exp_q [$];
    exp_t        mon_e;

    leb128_reader_if #(.ADDR_W(32)) bus ();

    leb128_reader #(.ADDR_W(32), .MAX_BYTES(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rom_addr   (rom_addr),
        .rom_read_en(rom_read_en),
        .rom_data   (rom_data),
        .rom_ready  (rom_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: two-cycle read, ignores a read of the address it answered last.
    always @(posedge clk) begin
        rom_ready <= 1'b0;
        if (rom_read_en && rom_addr != rom_last) begin
            rom_ready <= 1'b1;
            rom_data  <= mem[rom_addr[7:0]];
            rom_last  <= rom_addr;
            rom_reads <= rom_reads + 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.req_valid && bus.req_ready)
            acc_cyc <= cyc;
    end

    always @(negedge clk)
        if (rom_read_en) en_cycles <= en_cycles + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got value 0x%08h with no request pending", bus.rsp_value);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_value", bus.rsp_value, mon_e.value);
                chk("rsp_len", 32'(bus.rsp_len), 32'(mon_e.len));
                chk("rsp_next_addr", bus.rsp_next_addr, mon_e.nxt);
                chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                chk("latency", 32'(cyc - acc_cyc - 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_rsp_value"}, bus.rsp_value, 32'd0);
        chk({tag, "_rsp_len"}, 32'(bus.rsp_len), 32'd0);
        chk({tag, "_rsp_next_addr"}, bus.rsp_next_addr, 32'd0);
        chk({tag, "_rom_read_en"}, 32'(rom_read_en), 32'd0);
        chk({tag, "_rom_addr"}, rom_addr, 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic s, input logic push, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1 at addr 0x%08h", a);
        end
        if (push) exp_q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_signed = s;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic exp_t mk(input logic [31:0] v, input logic [2:0] l, input logic [31:0] nx,
                                input logic er, input int lt);
        exp_t e;
        e.value = v; e.len = l; e.nxt = nx; e.err = er; e.lat = lt;
        return e;
    endfunction

    initial begin
        int r0, e0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h05;
        mem[8'h20] = 8'hE5; mem[8'h21] = 8'h8E; mem[8'h22] = 8'h26;
        mem[8'h30] = 8'h7F;
        for (int i = 0; i < 5; i++) mem[8'h40 + i] = 8'h80;
        mem[8'h45] = 8'h00;
        for (int i = 0; i < 4; i++) mem[8'h50 + i] = 8'hFF;
        mem[8'h54] = 8'h1F;

        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_signed = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        @(negedge clk) rst_n = 1'b1;

        issue(32'h10, 1'b0, 1'b1, mk(32'd5, 3'd1, 32'h11, 1'b0, 2));
        wait_done("byte1");

        e0 = en_cycles;
        issue(32'h10, 1'b0, 1'b1, mk(32'd5, 3'd1, 32'h11, 1'b0, 1));
        wait_done("cache_hit");
        chk("cache_hit_rom_read_en_cycles", 32'(en_cycles - e0), 32'd0);

        issue(32'h20, 1'b0, 1'b1, mk(32'h0009_8765, 3'd3, 32'h23, 1'b0, 6));
        wait_done("three_byte");

`ifdef LEB128_SIGNED_EN
        issue(32'h30, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 3'd1, 32'h31, 1'b0, 2));
`else
        issue(32'h30, 1'b1, 1'b1, mk(32'h0000_007F, 3'd1, 32'h31, 1'b0, 2));
`endif
        wait_done("signed_7f");

        r0 = rom_reads;
        issue(32'h40, 1'b0, 1'b1, mk(32'h0, 3'd5, 32'h45, 1'b1, 10));
        wait_done("overrun");
        chk("overrun_rom_reads", 32'(rom_reads - r0), 32'd5);

        issue(32'h50, 1'b0, 1'b1, mk(32'hFFFF_FFFF, 3'd5, 32'h55, 1'b1, 10));
        wait_done("fifth_byte");

        issue(32'h20, 1'b0, 1'b0, mk(32'h0, 3'd0, 32'h0, 1'b0, 0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        r0 = rom_reads;
        issue(32'h10, 1'b0, 1'b1, mk(32'd5, 3'd1, 32'h11, 1'b0, 2));
        wait_done("post_reset");
        chk("post_reset_rom_reads", 32'(rom_reads - r0), 32'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
